// File: rtl/icache_ctrl_pf.sv
// Read-only instruction-cache controller sitting between the fetch stage and
// the tag/data array. Demand misses refill a whole line from a line-wide
// memory port. The critical word is forwarded in the refill cycle. An optional
// next-line prefetch follows every demand refill. A flush during a demand
// refill lets the memory transaction finish and then drops its result.
module icache_ctrl_pf #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LINE_BYTES  = 64,
  parameter int WAYS        = 8,
  parameter int CACHE_BYTES = 32768,
  parameter int REPL_MODE   = 0,
  parameter int PREFETCH    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      req_valid,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      stall,
  output logic [ADDR_W-1:0]         q_addr,
  input  logic                      q_hit,
  input  logic [DATA_W-1:0]         q_data,
  input  logic [WAYS-1:0]           q_valid_mask,
  output logic [ADDR_W-1:0]         p_addr,
  input  logic                      p_hit,
  input  logic [WAYS-1:0]           p_valid_mask,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [LINE_BYTES*8-1:0]   mem_rdata,
  output logic                      upd_en,
  output logic [$clog2(WAYS)-1:0]   upd_way,
  output logic [ADDR_W-1:0]         upd_addr,
  output logic [LINE_BYTES*8-1:0]   upd_line,
  output logic [31:0]               perf_hits,
  output logic [31:0]               perf_misses
);

  localparam int SETS   = CACHE_BYTES / (LINE_BYTES * WAYS);
  localparam int OFF    = $clog2(LINE_BYTES);
  localparam int WOFF   = $clog2(DATA_W / 8);
  localparam int WORDS  = (LINE_BYTES * 8) / DATA_W;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = LINE_BYTES * 8;

  // The array geometry must resolve to a non-zero power-of-two set count.
  if (SETS < 1 || (SETS & (SETS - 1)) != 0) begin : g_cfg_check
    $error("icache_ctrl_pf: CACHE_BYTES/(LINE_BYTES*WAYS) must be a power of 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_PF_PROBE,
    S_PF_REQ,
    S_PF_WAIT
  } state_e;

  state_e                state_q, state_d;
  logic [7:0]            lfsr_q, lfsr_d;
  logic [WAY_W-1:0]      rr_q, rr_d;
  logic                  kill_q, kill_d;
  logic [ADDR_W-1:0]     line_q, line_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;
  logic                  upd_en_q, upd_en_d;
  logic [WAY_W-1:0]      upd_way_q, upd_way_d;
  logic [ADDR_W-1:0]     upd_addr_q, upd_addr_d;
  logic [LINE_W-1:0]     upd_line_q, upd_line_d;
  logic [31:0]           hits_q, hits_d;
  logic [31:0]           misses_q, misses_d;

  logic                  lfsr_fb;
  logic [WAYS-1:0]       vmask;
  logic                  all_valid;
  logic [WAY_W-1:0]      victim;
  logic [ADDR_W-1:0]     pf_addr;

  // Lowest-numbered way whose valid bit is clear; only meaningful when one exists.
  function automatic logic [WAY_W-1:0] first_invalid(input logic [WAYS-1:0] m);
    logic [WAY_W-1:0] w;
    w = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!m[i]) w = WAY_W'(i);
    end
    return w;
  endfunction

  // Line-aligned form of a byte address.
  function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
  endfunction

  // Index of the fetch word inside its line.
  function automatic logic [WIDX_W-1:0] widx_of(input logic [ADDR_W-1:0] a);
    return WIDX_W'((a >> WOFF) & ADDR_W'(WORDS - 1));
  endfunction

  // Pick one fetch word out of a returned line.
  function automatic logic [DATA_W-1:0] word_of(input logic [LINE_W-1:0] l,
                                                input logic [WIDX_W-1:0] idx);
    return l[idx*DATA_W +: DATA_W];
  endfunction

  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign pf_addr   = line_q + ADDR_W'(LINE_BYTES);

  assign q_addr      = req_addr;
  assign stall       = (state_q != S_IDLE);
  assign mem_req     = (state_q == S_MISS_REQ) || (state_q == S_PF_REQ);
  assign mem_addr    = mem_req ? line_q : '0;
  assign p_addr      = (state_q == S_PF_PROBE) ? pf_addr : '0;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign upd_en      = upd_en_q;
  assign upd_way     = upd_way_q;
  assign upd_addr    = upd_addr_q;
  assign upd_line    = upd_line_q;
  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;

  // Victim choice: fill invalid ways first, otherwise LFSR or round-robin.
  always_comb begin
    vmask     = (state_q == S_PF_PROBE) ? p_valid_mask : q_valid_mask;
    all_valid = &vmask;
    victim    = first_invalid(vmask);
    if (all_valid) begin
      victim = (REPL_MODE == 1) ? rr_q : lfsr_q[WAY_W-1:0];
    end
  end

  // Next-state and next-register logic for the lookup/refill/prefetch FSM.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[6:0], lfsr_fb};
    rr_d         = rr_q;
    kill_d       = kill_q;
    line_d       = line_q;
    widx_d       = widx_q;
    way_d        = way_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    upd_en_d     = 1'b0;
    upd_way_d    = upd_way_q;
    upd_addr_d   = upd_addr_q;
    upd_line_d   = upd_line_q;
    hits_d       = hits_q;
    misses_d     = misses_q;

    unique case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (req_valid && !flush) begin
          if (q_hit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = q_data;
            hits_d       = hits_q + 32'd1;
          end else begin
            line_d   = line_of(req_addr);
            widx_d   = widx_of(req_addr);
            way_d    = victim;
            if (all_valid && REPL_MODE == 1) rr_d = rr_q + 1'b1;
            misses_d = misses_q + 32'd1;
            state_d  = S_MISS_REQ;
          end
        end
      end

      S_MISS_REQ: begin
        if (flush) kill_d = 1'b1;
        if (mem_ready) state_d = S_MISS_WAIT;
      end

      S_MISS_WAIT: begin
        if (mem_rvalid) begin
          if (kill_q || flush) begin
            kill_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            upd_en_d     = 1'b1;
            upd_way_d    = way_q;
            upd_addr_d   = line_q;
            upd_line_d   = mem_rdata;
            resp_valid_d = 1'b1;
            resp_data_d  = word_of(mem_rdata, widx_q);
            state_d      = (PREFETCH != 0) ? S_PF_PROBE : S_IDLE;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end

      S_PF_PROBE: begin
        if (p_hit) begin
          state_d = S_IDLE;
        end else begin
          line_d  = pf_addr;
          way_d   = victim;
          if (all_valid && REPL_MODE == 1) rr_d = rr_q + 1'b1;
          state_d = S_PF_REQ;
        end
      end

      S_PF_REQ: begin
        if (mem_ready) state_d = S_PF_WAIT;
      end

      S_PF_WAIT: begin
        if (mem_rvalid) begin
          upd_en_d   = 1'b1;
          upd_way_d  = way_q;
          upd_addr_d = line_q;
          upd_line_d = mem_rdata;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every output immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lfsr_q       <= 8'hFF;
      rr_q         <= '0;
      kill_q       <= 1'b0;
      line_q       <= '0;
      widx_q       <= '0;
      way_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      upd_en_q     <= 1'b0;
      upd_way_q    <= '0;
      upd_addr_q   <= '0;
      upd_line_q   <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      rr_q         <= rr_d;
      kill_q       <= kill_d;
      line_q       <= line_d;
      widx_q       <= widx_d;
      way_q        <= way_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      upd_en_q     <= upd_en_d;
      upd_way_q    <= upd_way_d;
      upd_addr_q   <= upd_addr_d;
      upd_line_q   <= upd_line_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl_pf.sv
// Directed testbench for icache_ctrl_pf. One instance uses the default
// configuration (LFSR replacement, prefetch on). A second instance uses
// round-robin replacement with prefetch off.
module tb_icache_ctrl_pf;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         req_valid, q_hit, p_hit, mem_ready, mem_rvalid;
  logic [31:0]  req_addr, q_data;
  logic [7:0]   q_valid_mask, p_valid_mask;
  logic [511:0] mem_rdata;

  logic         resp_valid, stall, mem_req, upd_en;
  logic [31:0]  resp_data, q_addr, p_addr, mem_addr, upd_addr, perf_hits, perf_misses;
  logic [2:0]   upd_way;
  logic [511:0] upd_line;

  logic         b_req_valid, b_q_hit, b_mem_ready, b_mem_rvalid;
  logic [31:0]  b_req_addr;
  logic [7:0]   b_q_valid_mask;
  logic         b_resp_valid, b_stall, b_mem_req, b_upd_en;
  logic [31:0]  b_resp_data, b_q_addr, b_p_addr, b_mem_addr, b_upd_addr, b_perf_hits, b_perf_misses;
  logic [2:0]   b_upd_way;
  logic [511:0] b_upd_line;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_hits   = 0;
  logic [31:0] exp_misses = 0;
  logic [7:0]  m_lfsr;

  always #5 clk = ~clk;

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, stepping every cycle from 8'hFF.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hFF;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  icache_ctrl_pf #(.REPL_MODE(0), .PREFETCH(1)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .stall(stall),
    .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data), .q_valid_mask(q_valid_mask),
    .p_addr(p_addr), .p_hit(p_hit), .p_valid_mask(p_valid_mask),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .upd_en(upd_en), .upd_way(upd_way), .upd_addr(upd_addr), .upd_line(upd_line),
    .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  icache_ctrl_pf #(.REPL_MODE(1), .PREFETCH(0)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(b_req_valid), .req_addr(b_req_addr),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .stall(b_stall),
    .q_addr(b_q_addr), .q_hit(b_q_hit), .q_data(q_data), .q_valid_mask(b_q_valid_mask),
    .p_addr(b_p_addr), .p_hit(p_hit), .p_valid_mask(p_valid_mask),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ready(b_mem_ready),
    .mem_rvalid(b_mem_rvalid), .mem_rdata(mem_rdata),
    .upd_en(b_upd_en), .upd_way(b_upd_way), .upd_addr(b_upd_addr), .upd_line(b_upd_line),
    .perf_hits(b_perf_hits), .perf_misses(b_perf_misses)
  );

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_tests++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem: req=%b addr=%h want 0/0", mem_req, mem_addr); end
    n_tests++; if (upd_en !== 1'b0 || p_addr !== 32'h0) begin n_fail++; $display("FAIL reset_upd_p: upd_en=%b p_addr=%h want 0/0", upd_en, p_addr); end
    n_tests++; if (perf_hits !== 32'h0 || perf_misses !== 32'h0) begin n_fail++; $display("FAIL reset_perf: hits=%0d misses=%0d want 0/0", perf_hits, perf_misses); end
    n_tests++; if (b_mem_req !== 1'b0 || b_upd_en !== 1'b0 || b_resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dut1: req=%b upd=%b resp=%b want 0", b_mem_req, b_upd_en, b_resp_valid); end
    rst = 1'b0;
  endtask

  task automatic test_hit();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h1000; q_hit = 1'b1; q_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (q_addr !== 32'h1000) begin n_fail++; $display("FAIL hit_q_addr: got %h want 00001000", q_addr); end
    @(negedge clk);
    req_valid = 1'b0;
    exp_hits = exp_hits + 1;
    n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_resp: valid=%b data=%h want 1/deadbeef", resp_valid, resp_data); end
    n_tests++; if (perf_hits !== exp_hits || perf_misses !== exp_misses) begin n_fail++; $display("FAIL hit_perf: hits=%0d misses=%0d want %0d/%0d", perf_hits, perf_misses, exp_hits, exp_misses); end
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: mem_req=%b stall=%b want 0/0", mem_req, stall); end
    @(negedge clk);
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: resp_valid=%b want 0", resp_valid); end
  endtask

  task automatic test_miss_invalid();
    @(negedge clk);
    mem_rdata = mk_line(32'hA000_0000);
    req_valid = 1'b1; req_addr = 32'h2024; q_hit = 1'b0; q_valid_mask = 8'b1111_0111; p_hit = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_misses = exp_misses + 1;
    n_tests++; if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h2000) begin n_fail++; $display("FAIL miss_req: stall=%b req=%b addr=%h want 1/1/00002000", stall, mem_req, mem_addr); end
    n_tests++; if (perf_misses !== exp_misses || perf_hits !== exp_hits) begin n_fail++; $display("FAIL miss_perf: misses=%0d hits=%0d want %0d/%0d", perf_misses, perf_hits, exp_misses, exp_hits); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000) begin n_fail++; $display("FAIL miss_hold: cycle %0d req=%b addr=%h want 1/00002000", c, mem_req, mem_addr); end
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_tests++; if (mem_req !== 1'b0 || stall !== 1'b1) begin n_fail++; $display("FAIL miss_accept: req=%b stall=%b want 0/1", mem_req, stall); end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b1 || upd_way !== 3'd3 || upd_addr !== 32'h2000) begin n_fail++; $display("FAIL miss_upd: en=%b way=%0d addr=%h want 1/3/00002000", upd_en, upd_way, upd_addr); end
    n_tests++; if (upd_line !== mk_line(32'hA000_0000)) begin n_fail++; $display("FAIL miss_upd_line: got %h", upd_line[63:0]); end
    n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'hA000_0009) begin n_fail++; $display("FAIL miss_cw: valid=%b data=%h want 1/a0000009", resp_valid, resp_data); end
    n_tests++; if (p_addr !== 32'h2040 || stall !== 1'b1) begin n_fail++; $display("FAIL miss_probe: p_addr=%h stall=%b want 00002040/1", p_addr, stall); end
    @(negedge clk);
    n_tests++; if (stall !== 1'b0 || upd_en !== 1'b0 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL miss_idle: stall=%b upd=%b resp=%b req=%b want 0", stall, upd_en, resp_valid, mem_req); end
  endtask

  task automatic test_prefetch();
    logic [2:0] exp_way;
    @(negedge clk);
    mem_rdata = mk_line(32'hA000_0000);
    req_valid = 1'b1; req_addr = 32'h3000; q_hit = 1'b0; q_valid_mask = 8'hFF;
    p_hit = 1'b0; p_valid_mask = 8'hFE;
    exp_way = m_lfsr[2:0];
    @(negedge clk);
    req_valid = 1'b0;
    exp_misses = exp_misses + 1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000) begin n_fail++; $display("FAIL pf_demand_req: req=%b addr=%h want 1/00003000", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b1 || upd_way !== exp_way) begin n_fail++; $display("FAIL lfsr_victim: en=%b way=%0d want 1/%0d", upd_en, upd_way, exp_way); end
    n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'hA000_0000 || p_addr !== 32'h3040) begin n_fail++; $display("FAIL pf_probe: resp=%b data=%h p_addr=%h want 1/a0000000/00003040", resp_valid, resp_data, p_addr); end
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h3040 || upd_en !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL pf_req: req=%b addr=%h upd=%b resp=%b want 1/00003040/0/0", mem_req, mem_addr, upd_en, resp_valid); end
    req_valid = 1'b1; req_addr = 32'h1000; q_hit = 1'b1; q_data = 32'h0BAD_F00D;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    n_tests++; if (resp_valid !== 1'b0 || perf_hits !== exp_hits || stall !== 1'b1) begin n_fail++; $display("FAIL pf_stall_req: resp=%b hits=%0d stall=%b want 0/%0d/1", resp_valid, perf_hits, stall, exp_hits); end
    flush = 1'b1;
    mem_rdata = mk_line(32'hB000_0000);
    @(negedge clk);
    flush = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b1 || upd_way !== 3'd0 || upd_addr !== 32'h3040) begin n_fail++; $display("FAIL pf_upd: en=%b way=%0d addr=%h want 1/0/00003040", upd_en, upd_way, upd_addr); end
    n_tests++; if (upd_line !== mk_line(32'hB000_0000) || resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL pf_noresp: line_lo=%h resp=%b stall=%b want b0000001b0000000/0/0", upd_line[63:0], resp_valid, stall); end
    @(negedge clk);
    n_tests++; if (upd_en !== 1'b0) begin n_fail++; $display("FAIL pf_upd_pulse: upd_en=%b want 0", upd_en); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h1000; q_hit = 1'b1; q_data = 32'h0000_0055;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n_tests++; if (resp_valid !== 1'b0 || perf_hits !== exp_hits || perf_misses !== exp_misses) begin n_fail++; $display("FAIL flush_idle: resp=%b hits=%0d misses=%0d want 0/%0d/%0d", resp_valid, perf_hits, perf_misses, exp_hits, exp_misses); end
    req_valid = 1'b1; req_addr = 32'h4000; q_hit = 1'b0; q_valid_mask = 8'hFE; p_hit = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    exp_misses = exp_misses + 1;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h4000) begin n_fail++; $display("FAIL flush_miss_req: req=%b addr=%h want 1/00004000", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL flush_wait: stall=%b req=%b want 1/0", stall, mem_req); end
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_kill: upd=%b resp=%b stall=%b want 0/0/0", upd_en, resp_valid, stall); end
    req_valid = 1'b1; req_addr = 32'h4000; q_hit = 1'b1; q_data = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    exp_hits = exp_hits + 1;
    n_tests++; if (resp_valid !== 1'b1 || resp_data !== 32'h1234_5678 || perf_hits !== exp_hits) begin n_fail++; $display("FAIL flush_next_hit: resp=%b data=%h hits=%0d want 1/12345678/%0d", resp_valid, resp_data, perf_hits, exp_hits); end
  endtask

  task automatic test_round_robin();
    logic [31:0] addrs [3];
    addrs[0] = 32'h5000; addrs[1] = 32'h5044; addrs[2] = 32'h5088;
    mem_rdata = mk_line(32'hA000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_req_valid = 1'b1; b_req_addr = addrs[i]; b_q_hit = 1'b0; b_q_valid_mask = 8'hFF;
      #1;
      n_tests++; if (b_q_addr !== addrs[i]) begin n_fail++; $display("FAIL rr_q_addr%0d: got %h want %h", i, b_q_addr, addrs[i]); end
      @(negedge clk);
      b_req_valid = 1'b0;
      n_tests++; if (b_mem_req !== 1'b1 || b_mem_addr !== (addrs[i] & 32'hFFFF_FFC0)) begin n_fail++; $display("FAIL rr_req%0d: req=%b addr=%h", i, b_mem_req, b_mem_addr); end
      b_mem_ready = 1'b1;
      @(negedge clk);
      b_mem_ready = 1'b0; b_mem_rvalid = 1'b1;
      @(negedge clk);
      b_mem_rvalid = 1'b0;
      n_tests++; if (b_upd_en !== 1'b1 || b_upd_way !== 3'(i) || b_upd_addr !== (addrs[i] & 32'hFFFF_FFC0)) begin n_fail++; $display("FAIL rr_way%0d: en=%b way=%0d addr=%h want 1/%0d", i, b_upd_en, b_upd_way, b_upd_addr, i); end
      n_tests++; if (b_resp_valid !== 1'b1 || b_resp_data !== 32'hA000_0000 + 32'(i) || b_stall !== 1'b0 || b_p_addr !== 32'h0) begin n_fail++; $display("FAIL rr_resp%0d: resp=%b data=%h stall=%b p_addr=%h", i, b_resp_valid, b_resp_data, b_stall, b_p_addr); end
      n_tests++; if (b_upd_line !== mk_line(32'hA000_0000)) begin n_fail++; $display("FAIL rr_line%0d: got %h", i, b_upd_line[63:0]); end
    end
    n_tests++; if (b_perf_misses !== 32'd3 || b_perf_hits !== 32'd0) begin n_fail++; $display("FAIL rr_perf: misses=%0d hits=%0d want 3/0", b_perf_misses, b_perf_hits); end
  endtask

  task automatic test_wrap_reset();
    @(negedge clk);
    mem_rdata = mk_line(32'hC000_0000);
    req_valid = 1'b1; req_addr = 32'hFFFF_FFC0; q_hit = 1'b0; q_valid_mask = 8'hFE;
    p_hit = 1'b0; p_valid_mask = 8'hFD;
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFC0) begin n_fail++; $display("FAIL wrap_req: req=%b addr=%h want 1/ffffffc0", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b1 || stall !== 1'b1 || p_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_probe: upd=%b stall=%b p_addr=%h want 1/1/00000000", upd_en, stall, p_addr); end
    @(negedge clk);
    n_tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_pf_req: req=%b addr=%h want 1/00000000", mem_req, mem_addr); end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    n_tests++; if (stall !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_pf_wait: stall=%b req=%b want 1/0", stall, mem_req); end
    rst = 1'b1;
    #1;
    n_tests++; if (stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0 || p_addr !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl: stall=%b req=%b addr=%h p=%h want 0", stall, mem_req, mem_addr, p_addr); end
    n_tests++; if (upd_en !== 1'b0 || upd_way !== 3'd0 || upd_addr !== 32'h0 || upd_line !== 512'h0) begin n_fail++; $display("FAIL rst_upd: en=%b way=%0d addr=%h want 0", upd_en, upd_way, upd_addr); end
    n_tests++; if (resp_valid !== 1'b0 || resp_data !== 32'h0 || perf_hits !== 32'h0 || perf_misses !== 32'h0) begin n_fail++; $display("FAIL rst_resp_perf: resp=%b data=%h hits=%0d misses=%0d want 0", resp_valid, resp_data, perf_hits, perf_misses); end
    exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    n_tests++; if (upd_en !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid: upd=%b resp=%b stall=%b want 0/0/0", upd_en, resp_valid, stall); end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = 32'h0; q_hit = 1'b0; q_data = 32'h0;
    q_valid_mask = 8'h00; p_hit = 1'b1; p_valid_mask = 8'hFF;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    b_req_valid = 1'b0; b_req_addr = 32'h0; b_q_hit = 1'b0; b_q_valid_mask = 8'hFF;
    b_mem_ready = 1'b0; b_mem_rvalid = 1'b0;
    test_reset();
    test_hit();
    test_miss_invalid();
    test_prefetch();
    test_flush();
    test_round_robin();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
